// File: rtl/decimator.sv
// decimator: groups 2^k accepted samples and emits one pick/average/peak result per group
module decimator #(
    parameter int WIDTH    = 10,
    parameter int MAX_LOG2 = 4,
    localparam int FW = (MAX_LOG2 > 0) ? $clog2(MAX_LOG2 + 1) : 1,
    localparam int CW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1,
    localparam int SW = WIDTH + MAX_LOG2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    flush,
    input  logic [1:0]              mode,
    input  logic [FW-1:0]           factor_log2,
    input  logic signed [WIDTH-1:0] data_in,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    valid_out
);
    logic [CW-1:0]           cnt;
    logic [1:0]              mode_q;
    logic [1:0]              mode_eff;
    logic [FW-1:0]           f_q;
    logic [FW-1:0]           f_in;
    logic [FW-1:0]           f_eff;
    logic signed [SW-1:0]    acc;
    logic signed [SW-1:0]    acc_base;
    logic signed [SW-1:0]    din_x;
    logic signed [SW-1:0]    sum;
    logic signed [WIDTH-1:0] peak;
    logic signed [WIDTH-1:0] peak_nx;
    logic signed [WIDTH-1:0] result;
    logic                    first;
    logic                    last;

    // Index 0 uses the live mode/factor (they are latched on that same edge);
    // later indices use the latched copies so mid-group changes wait a group.
    always_comb begin
        first    = cnt == '0;
        f_in     = (factor_log2 > FW'(MAX_LOG2)) ? FW'(MAX_LOG2) : factor_log2;
        f_eff    = first ? f_in : f_q;
        mode_eff = first ? mode : mode_q;
        last     = cnt == ~({CW{1'b1}} << f_eff);
        din_x    = {{MAX_LOG2{data_in[WIDTH-1]}}, data_in};
        acc_base = first ? '0 : acc;
        sum      = acc_base + din_x;
        peak_nx  = (first || data_in > peak) ? data_in : peak;
        result   = (mode_eff == 2'd1) ? WIDTH'(sum >>> f_eff) :
                   (mode_eff == 2'd2) ? peak_nx : data_in;
    end

    // Group state and registered output; flush drops the partial group but keeps data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mode_q    <= '0;
            f_q       <= '0;
            acc       <= '0;
            peak      <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else if (flush) begin
            cnt       <= '0;
            acc       <= '0;
            peak      <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= en && last;
            if (en) begin
                if (first) begin
                    mode_q <= mode;
                    f_q    <= f_in;
                end
                cnt  <= last ? '0 : cnt + CW'(1);
                acc  <= sum;
                peak <= peak_nx;
                if (last) data_out <= result;
            end
        end
    end
endmodule

// File: tb/tb_decimator.sv
// tb_decimator: directed self-checking bench for decimator
module tb_decimator;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [2:0]        factor_log2 = 3'd0;
    logic signed [9:0] data_in = '0;
    logic signed [9:0] data_out;
    logic              valid_out;
    int                total = 0;
    int                fails = 0;

    decimator #(.WIDTH(10), .MAX_LOG2(4)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .mode(mode),
        .factor_log2(factor_log2), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input int d);
        en = e;
        data_in = 10'(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input int v, input int d);
        chk({tag, "_valid"}, int'(valid_out), v);
        chk({tag, "_data"}, int'(data_out), d);
    endtask

    task automatic grp4(input string tag, input int a, input int b, input int c, input int d, input int exp);
        step(1'b1, a); chk({tag, "_v0"}, int'(valid_out), 0);
        step(1'b1, b); chk({tag, "_v1"}, int'(valid_out), 0);
        step(1'b1, c); chk({tag, "_v2"}, int'(valid_out), 0);
        step(1'b1, d); chk_out(tag, 1, exp);
        step(1'b0, 0); chk_out({tag, "_hold"}, 0, exp);
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 0);
        chk_out("reset", 0, 0);
        rst = 1'b0;

        mode = 2'd0; factor_log2 = 3'd2;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i);
            chk("pick_valid", int'(valid_out), (i % 4 == 3) ? 1 : 0);
            if (i % 4 == 3) chk("pick_data", int'(data_out), i);
        end
        step(1'b0, 0); chk_out("pick_hold", 0, 19);

        mode = 2'd1;
        grp4("avg_pos", 1, 2, 3, 4, 2);
        grp4("avg_neg", -1, -2, -3, -4, -3);
        factor_log2 = 3'd4;
        for (int i = 0; i < 16; i++) step(1'b1, -512);
        chk_out("avg_min", 1, -512);
        for (int i = 0; i < 16; i++) step(1'b1, 511);
        chk_out("avg_max", 1, 511);

        mode = 2'd2; factor_log2 = 3'd2;
        grp4("peak_a", 5, -9, 2, 7, 7);
        grp4("peak_b", -8, -3, -6, -5, -3);

        mode = 2'd0;
        step(1'b1, 10); chk("gap_v10", int'(valid_out), 0);
        step(1'b1, 11); chk("gap_v11", int'(valid_out), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 99); chk_out("gap_idle", 0, -3);
        end
        step(1'b1, 12); chk("gap_v12", int'(valid_out), 0);
        step(1'b1, 13); chk_out("gap_end", 1, 13);

        step(1'b1, 20);
        step(1'b1, 21);
        factor_log2 = 3'd1;
        step(1'b1, 22); chk("fchg_v22", int'(valid_out), 0);
        step(1'b1, 23); chk_out("fchg_4", 1, 23);
        step(1'b1, 24); chk("fchg_v24", int'(valid_out), 0);
        step(1'b1, 25); chk_out("fchg_2", 1, 25);

        mode = 2'd2;
        step(1'b1, 5);
        mode = 2'd0;
        step(1'b1, 3); chk_out("mode_latch", 1, 5);

        factor_log2 = 3'd7;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 30 + i);
            if (i < 15) chk("clamp_v", int'(valid_out), 0);
        end
        chk_out("clamp_16", 1, 45);

        factor_log2 = 3'd0;
        mode = 2'd0; step(1'b1, 17);  chk_out("n1_pick", 1, 17);
        mode = 2'd1; step(1'b1, -7);  chk_out("n1_avg", 1, -7);
        mode = 2'd2; step(1'b1, -100); chk_out("n1_peak", 1, -100);
        mode = 2'd3; step(1'b1, -1);  chk_out("n1_pick3", 1, -1);

        mode = 2'd1; factor_log2 = 3'd2;
        step(1'b1, 100);
        step(1'b1, 100);
        flush = 1'b1;
        step(1'b1, 77); chk_out("flush", 0, -1);
        flush = 1'b0;
        grp4("after_flush", 1, 2, 3, 4, 2);

        step(1'b1, 100);
        step(1'b1, 100);
        rst = 1'b1;
        step(1'b1, 100); chk_out("mid_rst", 0, 0);
        rst = 1'b0;
        step(1'b1, 1); chk_out("rst_1", 0, 0);
        step(1'b1, 2); chk_out("rst_2", 0, 0);
        step(1'b1, 3); chk_out("rst_3", 0, 0);
        step(1'b1, 4); chk_out("rst_4", 1, 2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/decimator.md
DECIMATOR -- requirements
Module: decimator

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning sample width (signed two's complement).
REQ-002 SHALL have parameter MAX_LOG2, default 4, meaning the largest decimation exponent; the maximum factor is 2^MAX_LOG2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: sample accept; data_in is consumed only on cycles with en=1.
REQ-006 SHALL have port flush, input, 1 bit: discards the partial group.
REQ-007 SHALL have port mode, input, 2 bits: 0=pick, 1=average, 2=peak (max), 3=pick.
REQ-008 SHALL have port factor_log2, input, clog2(MAX_LOG2+1) bits: decimation factor N = 2^factor_log2.
REQ-009 SHALL have port data_in, input, WIDTH bits, signed: input sample.
REQ-010 SHALL have port data_out, output, WIDTH bits, signed: decimated sample, registered.
REQ-011 SHALL have port valid_out, output, 1 bit: one-cycle pulse qualifying data_out.

Function
REQ-012 SHALL group accepted samples into groups of N; the sample index counter advances only on en=1, wraps N-1 -> 0, and holds while en=0.
REQ-013 SHALL latch mode and factor_log2 when index 0 of a group is accepted; changes mid-group SHALL take effect at the next group only.
REQ-014 SHALL clamp factor_log2 values above MAX_LOG2 to MAX_LOG2 at latch time.
REQ-015 SHALL, in pick mode, emit the last sample of each group (index N-1).
REQ-016 SHALL, in average mode, accumulate the group in a WIDTH+MAX_LOG2-bit signed sum (no overflow possible) and emit sum arithmetically shifted right by the latched factor_log2, which rounds toward negative infinity.
REQ-017 SHALL, in peak mode, emit the signed maximum of the group.
REQ-018 SHALL assert valid_out and update data_out on the clock edge following acceptance of index N-1 (latency 1 cycle); valid_out SHALL be high for exactly one cycle per group.
REQ-019 SHALL hold data_out at its last emitted value between pulses.
REQ-020 SHALL, for N=1 (factor_log2=0), emit every accepted sample with valid_out high on each following cycle, in all modes.
REQ-021 SHALL, when flush=1, clear the counter and the accumulator/peak register, discard any sample presented that cycle, suppress valid_out on the next cycle, and leave data_out unchanged.
REQ-022 SHALL start a new group at the first accepted sample after en returns high or after flush deasserts; no samples are lost or duplicated.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, set data_out=0, valid_out=0, counter=0, accumulator=0, peak register=0, latched mode=0 and latched factor_log2=0.
REQ-024 SHALL give rst priority over flush and en; a reset mid-group SHALL discard the partial group, and the next accepted sample SHALL be index 0.

Verification (WIDTH=10, MAX_LOG2=4)
REQ-025 Pick, factor_log2=2, en=1, inputs 0..19 -> five valid_out pulses, each one cycle after inputs 3, 7, 11, 15, 19, with data_out 3, 7, 11, 15, 19 respectively.
REQ-026 Average, factor_log2=2: inputs 1,2,3,4 -> 2; inputs -1,-2,-3,-4 -> -3; sixteen inputs of -512 at factor_log2=4 -> -512; sixteen inputs of 511 -> 511.
REQ-027 Peak, factor_log2=2, inputs 5,-9,2,7 -> 7; inputs -8,-3,-6,-5 -> -3.
REQ-028 Pick, factor_log2=2: accept 10 and 11, hold en=0 for 3 cycles, accept 12 and 13 -> exactly one pulse, data_out=13, and no valid_out during the en=0 cycles.
REQ-029 Set factor_log2 from 2 to 1 after index 1 of a group -> the current group still completes at 4 samples, the next group completes at 2; factor_log2=7 -> behaves as N=16.
REQ-030 Average, factor_log2=2: accept 100 and 100, then either assert flush or assert rst, then accept 1,2,3,4 -> single output 2 with no pulse from the partial group; after rst, data_out reads 0 until that pulse.
